// File: rtl/bp_be_late_wb_arbiter.sv
// Round-robin arbiter for the shared late-writeback regfile port, feeding a
// one-entry output buffer that drains whenever the early writeback leaves the port idle.
module bp_be_late_wb_arbiter #(
    parameter int unsigned num_req_p      = 3,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [num_req_p-1:0]              req_fp_i,
    input  logic [5*num_req_p-1:0]            req_rd_addr_i,
    input  logic [data_width_p*num_req_p-1:0] req_data_i,
    input  logic [5*num_req_p-1:0]            req_fflags_i,

    input  logic                              port_busy_i,

    output logic                              late_iwb_v_o,
    output logic                              late_fwb_v_o,
    output logic [4:0]                        late_rd_addr_o,
    output logic [data_width_p-1:0]           late_data_o,
    output logic [4:0]                        late_fflags_o,
    output logic                              dispatch_hold_o
);

    localparam int unsigned PTR_W  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned CAND_W = PTR_W + 1;
    localparam logic [CAND_W-1:0] NUM_REQ_C = CAND_W'(num_req_p);
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(num_req_p - 1);
    localparam logic [7:0]        LIMIT_C   = 8'(starve_limit_p);

    // Unpacked per-requester views of the flat payload buses
    logic [4:0]              rd_arr     [num_req_p];
    logic [data_width_p-1:0] data_arr   [num_req_p];
    logic [4:0]              fflags_arr [num_req_p];

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
        assign rd_arr[gi]     = req_rd_addr_i[5*gi +: 5];
        assign data_arr[gi]   = req_data_i[data_width_p*gi +: data_width_p];
        assign fflags_arr[gi] = req_fflags_i[5*gi +: 5];
    end

    // Buffer and arbitration state
    logic                    buf_v_q,      buf_v_d;
    logic                    buf_fp_q,     buf_fp_d;
    logic [4:0]              buf_rd_q,     buf_rd_d;
    logic [data_width_p-1:0] buf_data_q,   buf_data_d;
    logic [4:0]              buf_fflags_q, buf_fflags_d;
    logic [PTR_W-1:0]        rr_ptr_q,     rr_ptr_d;
    logic [7:0]              starve_cnt_q, starve_cnt_d;

    logic                    drain;
    logic                    accept_ok;
    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic [CAND_W-1:0]       cand;
    logic                    transfer;
    logic                    drop_x0;
    logic                    load;
    logic                    sel_fp;
    logic [4:0]              sel_rd;

    assign drain     = buf_v_q & ~port_busy_i;
    assign accept_ok = ~buf_v_q | drain;

    // Scan from the pointer upward, wrapping, and take the first valid requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < num_req_p; k++) begin
            cand = {1'b0, rr_ptr_q} + CAND_W'(k);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!grant_found && req_v_i[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_ready
        assign req_ready_o[gi] = accept_ok & grant_found & (grant_idx == PTR_W'(gi));
    end

    assign transfer = accept_ok & grant_found;
    assign sel_fp   = req_fp_i[grant_idx];
    assign sel_rd   = rd_arr[grant_idx];
    // Integer writes to x0 are acknowledged but never reach the port
    assign drop_x0  = ~sel_fp & (sel_rd == 5'd0);
    assign load     = transfer & ~drop_x0;

    always_comb begin
        buf_v_d      = buf_v_q;
        buf_fp_d     = buf_fp_q;
        buf_rd_d     = buf_rd_q;
        buf_data_d   = buf_data_q;
        buf_fflags_d = buf_fflags_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;

        if (transfer) begin
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
        end

        if (load) begin
            buf_v_d      = 1'b1;
            buf_fp_d     = sel_fp;
            buf_rd_d     = sel_rd;
            buf_data_d   = data_arr[grant_idx];
            buf_fflags_d = fflags_arr[grant_idx];
        end else if (drain) begin
            buf_v_d = 1'b0;
        end

        if (!buf_v_q || drain) begin
            starve_cnt_d = 8'd0;
        end else if (port_busy_i && (starve_cnt_q != 8'hFF)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_v_q      <= 1'b0;
            buf_fp_q     <= 1'b0;
            buf_rd_q     <= '0;
            buf_data_q   <= '0;
            buf_fflags_q <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            buf_v_q      <= buf_v_d;
            buf_fp_q     <= buf_fp_d;
            buf_rd_q     <= buf_rd_d;
            buf_data_q   <= buf_data_d;
            buf_fflags_q <= buf_fflags_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign late_iwb_v_o    = drain & ~buf_fp_q;
    assign late_fwb_v_o    = drain &  buf_fp_q;
    assign late_rd_addr_o  = buf_rd_q;
    assign late_data_o     = buf_data_q;
    assign late_fflags_o   = buf_fflags_q;
    // Depends on registered state only, so the detector sees no path from port_busy_i
    assign dispatch_hold_o = buf_v_q & (starve_cnt_q >= LIMIT_C);

endmodule
